// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory
// req/ack handshakes, a per-wait watchdog, illegal-opcode traps and instret.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit SUPPORT_FENCE  = 1'b1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       immediate_control,
  output logic [1:0]       alu_operation,
  output logic             alu_src1,
  output logic             alu_src2,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             is_rtype,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_IARITH, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_FENCE, C_ILLEGAL
  } class_e;

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             wd_expired;

  function automatic class_e decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_R;
      7'b0010011: decode_class = C_IARITH;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      7'b1101111: decode_class = C_JAL;
      7'b1100111: decode_class = C_JALR;
      7'b0110111: decode_class = C_LUI;
      7'b0010111: decode_class = C_AUIPC;
      7'b0001111: decode_class = SUPPORT_FENCE ? C_FENCE : C_ILLEGAL;
      default:    decode_class = C_ILLEGAL;
    endcase
  endfunction

  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // The watchdog defaults to zero so every state change re-arms it for the next wait.
  always_comb begin
    state_d           = state_q;
    class_d           = class_q;
    wdog_d            = '0;
    cause_d           = cause_q;
    imem_req          = 1'b0;
    ir_write          = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    immediate_control = 3'd0;
    alu_operation     = 2'd0;
    alu_src1          = 1'b0;
    alu_src2          = 1'b0;
    reg_write         = 1'b0;
    wb_sel            = 2'd0;
    pc_write          = 1'b0;
    pc_src            = 2'd0;
    is_rtype          = 1'b0;
    trap              = 1'b0;
    retire            = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (TIMEOUT_CYCLES != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DECODE: begin
        class_d = decode_class(opcode);
        if (class_d == C_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else if (class_d == C_LUI || class_d == C_JAL || class_d == C_FENCE) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WB;
        case (class_q)
          C_R: begin
            alu_operation = 2'd3;
            is_rtype      = 1'b1;
          end
          C_IARITH: begin
            alu_operation     = 2'd3;
            immediate_control = 3'd1;
            alu_src2          = 1'b1;
          end
          C_LOAD, C_STORE: begin
            alu_operation     = 2'd2;
            immediate_control = (class_q == C_STORE) ? 3'd2 : 3'd1;
            alu_src2          = 1'b1;
            state_d           = S_MEM;
          end
          C_AUIPC: begin
            alu_operation     = 2'd2;
            immediate_control = 3'd4;
            alu_src1          = 1'b1;
            alu_src2          = 1'b1;
          end
          C_JALR: begin
            alu_operation     = 2'd2;
            immediate_control = 3'd1;
            alu_src2          = 1'b1;
          end
          C_BRANCH: begin
            alu_operation     = 2'd1;
            immediate_control = 3'd3;
            pc_write          = 1'b1;
            pc_src            = branch_taken ? 2'd1 : 2'd0;
            retire            = 1'b1;
            state_d           = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == C_STORE);
        if (dmem_ack) begin
          if (class_q == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (TIMEOUT_CYCLES != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_WB: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        case (class_q)
          C_R, C_IARITH, C_AUIPC: reg_write = 1'b1;
          C_LOAD: begin
            reg_write = 1'b1;
            wb_sel    = 2'd1;
          end
          C_LUI: begin
            reg_write         = 1'b1;
            wb_sel            = 2'd3;
            immediate_control = 3'd4;
          end
          C_JAL: begin
            reg_write         = 1'b1;
            wb_sel            = 2'd2;
            immediate_control = 3'd5;
            pc_src            = 2'd1;
          end
          C_JALR: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_src    = 2'd2;
          end
          default: ;
        endcase
      end
      S_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'd3;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= C_NONE;
      wdog_q    <= '0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wdog_q    <= wdog_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: an instruction-level model predicts
// the per-cycle control word for each instruction and its memory ack timing.
module tb_rv_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNTW    = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       imemReq, irWrite, dmemReq, dmemWe;
    logic [2:0] imm;
    logic [1:0] aluOp;
    logic       src1, src2, regWrite;
    logic [1:0] wbSel;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       isR, trap;
    logic [1:0] cause;
    logic       retire;
  } ctrl_t;

  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_FENCE, K_ILL} kind_e;

  logic clock = 1'b0;
  logic rstN = 1'b0;
  logic [6:0] opcode = '0;
  logic branchTaken = 1'b0, imemAck = 1'b0, dmemAck = 1'b0;
  logic imemReq, irWrite, dmemReq, dmemWe, aluSrc1, aluSrc2, regWrite, pcWrite;
  logic isRtype, trap, retire;
  logic [2:0] immCtl, stateO;
  logic [1:0] aluOp, wbSel, pcSrc, trapCause;
  logic [CNTW-1:0] instret;
  ctrl_t dutWord;

  int vectors = 0;
  int miscompares = 0;
  int modelInstret = 0;
  logic [1:0] modelCause = 2'd0;

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .SUPPORT_FENCE(1'b1), .CNT_W(CNTW)) dut (
    .clk(clock), .rst_n(rstN), .opcode(opcode), .branch_taken(branchTaken),
    .imem_ack(imemAck), .dmem_ack(dmemAck), .imem_req(imemReq), .ir_write(irWrite),
    .dmem_req(dmemReq), .dmem_we(dmemWe), .immediate_control(immCtl),
    .alu_operation(aluOp), .alu_src1(aluSrc1), .alu_src2(aluSrc2),
    .reg_write(regWrite), .wb_sel(wbSel), .pc_write(pcWrite), .pc_src(pcSrc),
    .is_rtype(isRtype), .trap(trap), .trap_cause(trapCause), .retire(retire),
    .instret(instret), .state_o(stateO)
  );

  assign dutWord = {stateO, imemReq, irWrite, dmemReq, dmemWe, immCtl, aluOp, aluSrc1,
                    aluSrc2, regWrite, wbSel, pcWrite, pcSrc, isRtype, trap, trapCause, retire};

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic kind_e opKind(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b0001111: return K_FENCE;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic ctrl_t base(input logic [2:0] st);
    ctrl_t e = '0;
    e.st    = st;
    e.cause = modelCause;
    return e;
  endfunction

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic cycleCheck(input string tag, input ctrl_t e);
    @(negedge clock);
    checkOutput(tag, 32'(dutWord), 32'(e));
    @(posedge clock);
    #1;
  endtask

  task automatic releaseReset();
    @(posedge clock);
    #1 rstN = 1'b1;
    cycleCheck("idle", base(3'd0));
  endtask

  // One instruction, starting just after the edge that entered FETCH.
  task automatic applyStimulus(input logic [6:0] op, input int fDly, input int mDly,
                               input logic bt, input bit abortInMem);
    kind_e k = opKind(op);
    ctrl_t e;
    bit trapped = 0, done = 0, retired = 0;
    logic [1:0] newCause = 2'd0;
    opcode = op; branchTaken = bt; imemAck = 1'b0; dmemAck = 1'b0;
    checkOutput("instret", 32'(instret), 32'(modelInstret));
    for (int c = 0; c < TIMEOUT; c++) begin
      imemAck = (c == fDly);
      e = base(3'd1); e.imemReq = 1'b1; e.irWrite = imemAck;
      cycleCheck("fetch", e);
      if (imemAck) break;
      if (c == TIMEOUT - 1) begin trapped = 1; newCause = 2'd2; end
    end
    imemAck = 1'b0;
    if (!trapped) begin
      cycleCheck("decode", base(3'd2));
      if (k == K_ILL) begin
        trapped = 1; newCause = 2'd1;
      end else begin
        if (!(k inside {K_LUI, K_JAL, K_FENCE})) begin
          e = base(3'd3);
          case (k)
            K_R:     begin e.aluOp = 2'd3; e.isR = 1'b1; end
            K_I:     begin e.aluOp = 2'd3; e.imm = 3'd1; e.src2 = 1'b1; end
            K_LOAD:  begin e.aluOp = 2'd2; e.imm = 3'd1; e.src2 = 1'b1; end
            K_STORE: begin e.aluOp = 2'd2; e.imm = 3'd2; e.src2 = 1'b1; end
            K_AUIPC: begin e.aluOp = 2'd2; e.imm = 3'd4; e.src1 = 1'b1; e.src2 = 1'b1; end
            K_JALR:  begin e.aluOp = 2'd2; e.imm = 3'd1; e.src2 = 1'b1; end
            default: begin
              e.aluOp = 2'd1; e.imm = 3'd3; e.pcWrite = 1'b1;
              e.pcSrc = bt ? 2'd1 : 2'd0; e.retire = 1'b1;
              done = 1; retired = 1;
            end
          endcase
          cycleCheck("execute", e);
        end
        if (!done && (k == K_LOAD || k == K_STORE)) begin
          for (int c = 0; c < TIMEOUT; c++) begin
            if (abortInMem && c == 1) begin
              dmemAck = 1'b0;
              #3 rstN = 1'b0;
              #1;
              checkOutput("rst_dmem_req", 32'(dmemReq), 32'd0);
              checkOutput("rst_state", 32'(stateO), 32'd0);
              checkOutput("rst_instret", 32'(instret), 32'd0);
              checkOutput("rst_word", 32'(dutWord), 32'd0);
              modelInstret = 0; modelCause = 2'd0;
              releaseReset();
              return;
            end
            dmemAck = (c == mDly);
            e = base(3'd4); e.dmemReq = 1'b1; e.dmemWe = (k == K_STORE);
            if (dmemAck && k == K_STORE) begin
              e.pcWrite = 1'b1; e.retire = 1'b1; done = 1; retired = 1;
            end
            cycleCheck("mem", e);
            if (dmemAck) break;
            if (c == TIMEOUT - 1) begin trapped = 1; newCause = 2'd3; end
          end
          dmemAck = 1'b0;
        end
        if (!done && !trapped) begin
          e = base(3'd5); e.pcWrite = 1'b1; e.retire = 1'b1; retired = 1;
          case (k)
            K_LOAD:  begin e.regWrite = 1'b1; e.wbSel = 2'd1; end
            K_LUI:   begin e.regWrite = 1'b1; e.wbSel = 2'd3; e.imm = 3'd4; end
            K_JAL:   begin e.regWrite = 1'b1; e.wbSel = 2'd2; e.imm = 3'd5; e.pcSrc = 2'd1; end
            K_JALR:  begin e.regWrite = 1'b1; e.wbSel = 2'd2; e.pcSrc = 2'd2; end
            K_FENCE: ;
            default: e.regWrite = 1'b1;
          endcase
          cycleCheck("wb", e);
        end
      end
    end
    if (trapped) begin
      modelCause = newCause;
      e = base(3'd6); e.trap = 1'b1; e.pcWrite = 1'b1; e.pcSrc = 2'd3;
      cycleCheck("trap", e);
    end
    if (retired) modelInstret = (modelInstret + 1) % (1 << CNTW);
  endtask

  logic [6:0] opTable [13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                               7'b1111111, 7'b1110011, 7'b0000000};

  initial begin
    releaseReset();
    applyStimulus(7'b0010011, 0, 0, 1'b0, 1'b0);   // ADDI
    applyStimulus(7'b0000011, 0, 3, 1'b0, 1'b0);   // LW, ack on the threshold cycle
    applyStimulus(7'b1100011, 1, 0, 1'b1, 1'b0);   // BEQ taken
    applyStimulus(7'b1100011, 0, 0, 1'b0, 1'b0);   // BEQ not taken
    applyStimulus(7'b1111111, 0, 0, 1'b0, 1'b0);   // illegal
    applyStimulus(7'b0010011, 9, 0, 1'b0, 1'b0);   // imem timeout
    applyStimulus(7'b0010011, 3, 0, 1'b0, 1'b0);   // imem ack on threshold
    applyStimulus(7'b0100011, 0, 9, 1'b0, 1'b0);   // dmem timeout
    applyStimulus(7'b0001111, 0, 0, 1'b0, 1'b0);   // FENCE
    for (int n = 0; n < 120; n++)
      applyStimulus(opTable[$urandom_range(0, 12)], $urandom_range(0, 4),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
    applyStimulus(7'b0100011, 0, 3, 1'b0, 1'b1);   // SW, reset during MEM
    for (int n = 0; n < 17; n++)
      applyStimulus(7'b0010011, 0, 0, 1'b0, 1'b0);
    checkOutput("instret_wrap", 32'(instret), 32'(modelInstret));
    checkOutput("instret_wrap_val", 32'(instret), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
